// File: rtl/output_classifier_pkg.sv
// Shared definitions for the output classifier: FSM state encoding and the
// output-layer word width derived from the network's fan-in and fraction width.
package output_classifier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Output-layer word: integer growth from summing nh1 products, sign bit, fraction.
   function automatic int word_width(input int nh1, input int wf);
      return $clog2(nh1) + 1 + wf;
   endfunction

endpackage

// File: rtl/output_classifier_argmax_step.sv
// One step of a serial argmax: keeps the current best unless the new lane is
// strictly greater (signed), so ties resolve to the lowest index.
module output_classifier_argmax_step #(
   parameter int W  = 11,
   parameter int IW = 1
) (
   input  logic signed [W-1:0]  best_val,
   input  logic        [IW-1:0] best_idx,
   input  logic signed [W-1:0]  lane_val,
   input  logic        [IW-1:0] lane_idx,
   output logic signed [W-1:0]  new_val,
   output logic        [IW-1:0] new_idx
);

   always_comb begin
      new_val = best_val;
      new_idx = best_idx;
      if (lane_val > best_val) begin
         new_val = lane_val;
         new_idx = lane_idx;
      end
   end

endmodule

// File: rtl/output_classifier.sv
// Serial argmax classifier for network output beats with hit detection against
// the teacher vector and saturating total/hit accuracy counters.
module output_classifier
   import output_classifier_pkg::*;
#(
   parameter int NO  = 2,
   parameter int NH1 = 3,
   parameter int WF  = 8,
   parameter int WC  = 16,
   localparam int WO = word_width(NH1, WF),
   localparam int IW = $clog2(NO)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iValid_AM_Output,
   output logic             oReady_AM_Output,
   input  logic [NO*WO-1:0] iData_AM_Output,
   input  logic [NO*WO-1:0] iData_AM_Teacher,
   output logic             oValid_BM_Class,
   input  logic             iReady_BM_Class,
   output logic [IW-1:0]    oData_BM_Class,
   output logic             oHit_BM_Class,
   input  logic             iClear,
   output logic [WC-1:0]    oCount_Total,
   output logic [WC-1:0]    oCount_Hit
);

   localparam logic [IW-1:0] LAST_LANE = IW'(NO - 1);
   localparam logic [WC-1:0] COUNT_MAX = '1;

   state_t state, next_state;

   logic [NO*WO-1:0]    out_q, teach_q;
   logic [IW-1:0]       lane;
   logic signed [WO-1:0] out_best_val, teach_best_val;
   logic [IW-1:0]       out_best_idx, teach_best_idx;
   logic signed [WO-1:0] out_lane_val, teach_lane_val;
   logic signed [WO-1:0] out_new_val, teach_new_val;
   logic [IW-1:0]       out_new_idx, teach_new_idx;
   logic                hit_q;
   logic                accept, handoff;

   assign accept  = iValid_AM_Output && oReady_AM_Output;
   assign handoff = oValid_BM_Class && iReady_BM_Class;

   assign out_lane_val   = out_q[int'(lane)*WO +: WO];
   assign teach_lane_val = teach_q[int'(lane)*WO +: WO];

   output_classifier_argmax_step #(.W(WO), .IW(IW)) u_out_step (
      .best_val (out_best_val),
      .best_idx (out_best_idx),
      .lane_val (out_lane_val),
      .lane_idx (lane),
      .new_val  (out_new_val),
      .new_idx  (out_new_idx)
   );

   output_classifier_argmax_step #(.W(WO), .IW(IW)) u_teach_step (
      .best_val (teach_best_val),
      .best_idx (teach_best_idx),
      .lane_val (teach_lane_val),
      .lane_idx (lane),
      .new_val  (teach_new_val),
      .new_idx  (teach_new_idx)
   );

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) state <= IDLE;
      else      state <= next_state;
   end

   // No bypass from DONE back to capture: a new beat waits one IDLE cycle.
   always_comb begin
      next_state       = state;
      oReady_AM_Output = 1'b0;
      oValid_BM_Class  = 1'b0;
      case (state)
         IDLE: begin
            oReady_AM_Output = 1'b1;
            if (iValid_AM_Output) next_state = SCAN;
         end
         SCAN: begin
            if (lane == LAST_LANE) next_state = DONE;
         end
         DONE: begin
            oValid_BM_Class = 1'b1;
            if (iReady_BM_Class) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         out_q          <= '0;
         teach_q        <= '0;
         lane           <= '0;
         out_best_val   <= '0;
         out_best_idx   <= '0;
         teach_best_val <= '0;
         teach_best_idx <= '0;
         hit_q          <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            out_q          <= iData_AM_Output;
            teach_q        <= iData_AM_Teacher;
            out_best_val   <= iData_AM_Output[WO-1:0];
            teach_best_val <= iData_AM_Teacher[WO-1:0];
            out_best_idx   <= '0;
            teach_best_idx <= '0;
            lane           <= IW'(1);
         end
      end else if (state == SCAN) begin
         out_best_val   <= out_new_val;
         out_best_idx   <= out_new_idx;
         teach_best_val <= teach_new_val;
         teach_best_idx <= teach_new_idx;
         lane           <= lane + IW'(1);
         if (lane == LAST_LANE) hit_q <= (out_new_idx == teach_new_idx);
      end
   end

   assign oData_BM_Class = out_best_idx;
   assign oHit_BM_Class  = hit_q;

   // Clear takes effect before the count, so a coincident handoff leaves a count of one.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         oCount_Total <= '0;
         oCount_Hit   <= '0;
      end else if (iClear) begin
         oCount_Total <= handoff ? WC'(1) : '0;
         oCount_Hit   <= (handoff && hit_q) ? WC'(1) : '0;
      end else if (handoff) begin
         if (oCount_Total != COUNT_MAX) oCount_Total <= oCount_Total + WC'(1);
         if (hit_q && oCount_Hit != COUNT_MAX) oCount_Hit <= oCount_Hit + WC'(1);
      end
   end

endmodule

// File: tb/tb_output_classifier.sv
// Directed self-checking bench: a 2-class instance with 4-bit counters plus a
// 4-class instance for tie-breaking and longer scan latency.
module tb_output_classifier;

   localparam int WO = 11;
   localparam int W2 = 2 * WO;
   localparam int W4 = 4 * WO;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic          a_valid = 1'b0, a_ready, a_cls_valid, a_cls_ready = 1'b0;
   logic [W2-1:0] a_out = '0, a_teach = '0;
   logic          a_cls, a_hit, a_clear = 1'b0;
   logic [3:0]    a_total, a_hits;

   logic          b_valid = 1'b0, b_ready, b_cls_valid, b_cls_ready = 1'b0;
   logic [W4-1:0] b_out = '0, b_teach = '0;
   logic [1:0]    b_cls;
   logic          b_hit;
   logic [3:0]    b_total, b_hits;

   output_classifier #(.NO(2), .NH1(3), .WF(8), .WC(4)) dut_a (
      .iCLK(clk), .iRST(rst),
      .iValid_AM_Output(a_valid), .oReady_AM_Output(a_ready),
      .iData_AM_Output(a_out), .iData_AM_Teacher(a_teach),
      .oValid_BM_Class(a_cls_valid), .iReady_BM_Class(a_cls_ready),
      .oData_BM_Class(a_cls), .oHit_BM_Class(a_hit),
      .iClear(a_clear), .oCount_Total(a_total), .oCount_Hit(a_hits)
   );

   output_classifier #(.NO(4), .NH1(3), .WF(8), .WC(4)) dut_b (
      .iCLK(clk), .iRST(rst),
      .iValid_AM_Output(b_valid), .oReady_AM_Output(b_ready),
      .iData_AM_Output(b_out), .iData_AM_Teacher(b_teach),
      .oValid_BM_Class(b_cls_valid), .iReady_BM_Class(b_cls_ready),
      .oData_BM_Class(b_cls), .oHit_BM_Class(b_hit),
      .iClear(1'b0), .oCount_Total(b_total), .oCount_Hit(b_hits)
   );

   // Present one beat for one edge, then put junk on the idle bus.
   task automatic drive_beat(input logic [W2-1:0] o, input logic [W2-1:0] t);
      @(negedge clk);
      a_valid = 1'b1; a_out = o; a_teach = t;
      @(posedge clk); #1;
      a_valid = 1'b0; a_out = W2'($urandom); a_teach = W2'($urandom);
   endtask

   task automatic wait_valid_a(output int n);
      n = 0;
      while (!a_cls_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
   endtask

   task automatic handshake_a();
      @(negedge clk); a_cls_ready = 1'b1;
      @(posedge clk); #1; a_cls_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      total++; if (a_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=1", a_ready); end
      total++; if (a_cls_valid !== 1'b0 || a_cls !== 1'b0 || a_hit !== 1'b0) begin bad++;
         $display("[TB] FAIL reset_outputs got valid=%b cls=%b hit=%b exp 0/0/0", a_cls_valid, a_cls, a_hit); end
      total++; if (a_total !== 4'd0 || a_hits !== 4'd0) begin bad++;
         $display("[TB] FAIL reset_counters got=%0d/%0d exp=0/0", a_total, a_hits); end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_basic();
      int n;
      drive_beat({11'h020, 11'h010}, {11'h100, 11'h000});
      total++; if (a_cls_valid !== 1'b0 || a_ready !== 1'b0) begin bad++;
         $display("[TB] FAIL basic_scan got valid=%b ready=%b exp 0/0", a_cls_valid, a_ready); end
      wait_valid_a(n);
      total++; if (n != 1) begin bad++; $display("[TB] FAIL basic_latency got=%0d exp=1", n); end
      total++; if (a_cls !== 1'b1 || a_hit !== 1'b1) begin bad++;
         $display("[TB] FAIL basic_result got cls=%b hit=%b exp 1/1", a_cls, a_hit); end
      handshake_a();
      total++; if (a_cls_valid !== 1'b0 || a_ready !== 1'b1) begin bad++;
         $display("[TB] FAIL basic_release got valid=%b ready=%b exp 0/1", a_cls_valid, a_ready); end
      total++; if (a_total !== 4'd1 || a_hits !== 4'd1) begin bad++;
         $display("[TB] FAIL basic_counters got=%0d/%0d exp=1/1", a_total, a_hits); end
   endtask

   task automatic test_signed();
      int n;
      drive_beat({11'h005, 11'h7F0}, {11'h000, 11'h100});
      wait_valid_a(n);
      total++; if (n != 1 || a_cls !== 1'b1 || a_hit !== 1'b0) begin bad++;
         $display("[TB] FAIL signed_result got n=%0d cls=%b hit=%b exp 1/1/0", n, a_cls, a_hit); end
      handshake_a();
      total++; if (a_total !== 4'd2 || a_hits !== 4'd1) begin bad++;
         $display("[TB] FAIL signed_counters got=%0d/%0d exp=2/1", a_total, a_hits); end
   endtask

   task automatic test_tie();
      int n;
      drive_beat({11'h040, 11'h040}, {11'h000, 11'h000});
      wait_valid_a(n);
      total++; if (n != 1 || a_cls !== 1'b0 || a_hit !== 1'b1) begin bad++;
         $display("[TB] FAIL tie2_result got n=%0d cls=%b hit=%b exp 1/0/1", n, a_cls, a_hit); end
      handshake_a();
      total++; if (a_total !== 4'd3 || a_hits !== 4'd2) begin bad++;
         $display("[TB] FAIL tie2_counters got=%0d/%0d exp=3/2", a_total, a_hits); end
      // Four classes: lanes {1,9,9,3}, teacher best at lane 3.
      @(negedge clk);
      b_valid = 1'b1;
      b_out   = {11'd3, 11'd9, 11'd9, 11'd1};
      b_teach = {11'd5, 11'd0, 11'd0, 11'd0};
      @(posedge clk); #1;
      b_valid = 1'b0; b_out = W4'({$urandom, $urandom});
      n = 0;
      while (!b_cls_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (n != 3) begin bad++; $display("[TB] FAIL tie4_latency got=%0d exp=3", n); end
      total++; if (b_cls !== 2'd1 || b_hit !== 1'b0) begin bad++;
         $display("[TB] FAIL tie4_result got cls=%0d hit=%b exp 1/0", b_cls, b_hit); end
      @(negedge clk); b_cls_ready = 1'b1;
      @(posedge clk); #1; b_cls_ready = 1'b0;
      total++; if (b_total !== 4'd1 || b_hits !== 4'd0 || b_ready !== 1'b1) begin bad++;
         $display("[TB] FAIL tie4_counters got=%0d/%0d ready=%b exp 1/0/1", b_total, b_hits, b_ready); end
   endtask

   task automatic test_stall();
      int n;
      int errs = 0;
      drive_beat({11'h001, 11'h002}, {11'h001, 11'h000});
      wait_valid_a(n);
      @(negedge clk);
      a_valid = 1'b1; a_out = {11'h300, 11'h000}; a_teach = '0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (a_cls_valid !== 1'b1 || a_cls !== 1'b0 || a_hit !== 1'b0 || a_ready !== 1'b0) errs++;
      end
      total++; if (errs != 0) begin bad++;
         $display("[TB] FAIL stall_hold got %0d bad cycles (valid=%b cls=%b hit=%b ready=%b) exp 0", errs, a_cls_valid, a_cls, a_hit, a_ready); end
      @(negedge clk); a_valid = 1'b0;
      handshake_a();
      total++; if (a_total !== 4'd4 || a_hits !== 4'd2) begin bad++;
         $display("[TB] FAIL stall_counters got=%0d/%0d exp=4/2", a_total, a_hits); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (a_cls_valid !== 1'b0) begin bad++;
         $display("[TB] FAIL stall_no_accept got valid=%b exp 0", a_cls_valid); end
   endtask

   task automatic test_saturate();
      int n;
      for (int i = 0; i < 20; i++) begin
         drive_beat({11'h020, 11'h010}, {11'h100, 11'h000});
         wait_valid_a(n);
         handshake_a();
      end
      total++; if (a_total !== 4'd15 || a_hits !== 4'd15) begin bad++;
         $display("[TB] FAIL saturate got=%0d/%0d exp=15/15", a_total, a_hits); end
      @(negedge clk); a_clear = 1'b1;
      @(posedge clk); #1; a_clear = 1'b0;
      total++; if (a_total !== 4'd0 || a_hits !== 4'd0) begin bad++;
         $display("[TB] FAIL clear_only got=%0d/%0d exp=0/0", a_total, a_hits); end
      drive_beat({11'h020, 11'h010}, {11'h100, 11'h000});
      wait_valid_a(n);
      @(negedge clk); a_clear = 1'b1; a_cls_ready = 1'b1;
      @(posedge clk); #1; a_clear = 1'b0; a_cls_ready = 1'b0;
      total++; if (a_total !== 4'd1 || a_hits !== 4'd1) begin bad++;
         $display("[TB] FAIL clear_with_handoff got=%0d/%0d exp=1/1", a_total, a_hits); end
   endtask

   task automatic test_reset_mid();
      int n;
      drive_beat({11'h020, 11'h010}, {11'h100, 11'h000});
      rst = 1'b1;
      #1;
      total++; if (a_cls_valid !== 1'b0 || a_ready !== 1'b1) begin bad++;
         $display("[TB] FAIL midreset_stream got valid=%b ready=%b exp 0/1", a_cls_valid, a_ready); end
      total++; if (a_total !== 4'd0 || a_hits !== 4'd0) begin bad++;
         $display("[TB] FAIL midreset_counters got=%0d/%0d exp=0/0", a_total, a_hits); end
      @(negedge clk); rst = 1'b0;
      drive_beat({11'h010, 11'h030}, {11'h000, 11'h100});
      wait_valid_a(n);
      total++; if (n != 1 || a_cls !== 1'b0 || a_hit !== 1'b1) begin bad++;
         $display("[TB] FAIL postreset_result got n=%0d cls=%b hit=%b exp 1/0/1", n, a_cls, a_hit); end
      handshake_a();
      total++; if (a_total !== 4'd1 || a_hits !== 4'd1) begin bad++;
         $display("[TB] FAIL postreset_counters got=%0d/%0d exp=1/1", a_total, a_hits); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_tie();
      test_stall();
      test_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
